// File: rtl/pipe_arb_pkg.sv
// Shared definitions for the pipeline-sharing arbiter: width helper, tag record
// layout {valid, tag} and the statistics counter width.
package pipe_arb_pkg;

  localparam int STATS_W   = 16;
  // Widest tag needed for the largest supported requester count (16).
  localparam int MAX_TAG_W = 4;

  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
  } tag_rec_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pipe_tag_delay.sv
// LATENCY-stage shift register carrying {valid, tag} alongside the shared
// pipeline so each pipeline output can be routed back to its requester.
module pipe_tag_delay
  import pipe_arb_pkg::*;
#(
  parameter int LATENCY = 5
) (
  input  logic     clk,
  input  logic     rst,
  input  tag_rec_t tag_i,
  output tag_rec_t tag_o
);

  tag_rec_t stage_q [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[LATENCY-1];

endmodule

// File: rtl/pipe_share_arbiter.sv
// Round-robin sharing of one fixed-latency, non-stallable pipeline among NUM_REQ
// requesters. Optional per-requester grant counters under PIPE_ARB_STATS_EN.
//
// Handshake: req_valid[i] may be raised at any time; a transfer happens in a cycle
// where req_valid[i] & req_ready[i]. At most one req_ready bit is ever set.
// Responses carry no backpressure: resp_valid is a one-cycle pulse that must be taken.
module pipe_share_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         pipe_din,
  output logic                          pipe_din_valid,
  input  logic [DATA_WIDTH-1:0]         pipe_dout,
  input  logic                          pipe_dout_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic                          busy,
`ifdef PIPE_ARB_STATS_EN
  output logic [NUM_REQ*STATS_W-1:0]    grant_cnt,
`endif
  output logic                          err_orphan
);

  localparam int TAG_W   = clog2(NUM_REQ);
  localparam int DRAIN_W = clog2(LATENCY + 1);
  localparam int IF_W    = clog2(LATENCY + 2);

  logic [TAG_W-1:0]      ptr_q, ptr_d;
  logic [TAG_W-1:0]      grant_idx;
  logic                  grant_found;
  logic [TAG_W:0]        cand;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  din_valid_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [TAG_W-1:0]      issue_tag_q;

  logic [DRAIN_W-1:0]    drain_q, drain_d;
  logic                  draining;
  logic [IF_W-1:0]       inflight_q, inflight_d;
  logic                  orphan_q, orphan_d;

  tag_rec_t              tag_in, tag_out;
  logic                  resp_hit;

  assign draining = (drain_q != '0);

  // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (arb_en && !draining) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, ptr_q} + (TAG_W+1)'(k);
        if (cand >= (TAG_W+1)'(NUM_REQ)) cand = cand - (TAG_W+1)'(NUM_REQ);
        if (!grant_found && req_valid[cand[TAG_W-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = cand[TAG_W-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == TAG_W'(i)) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_found) begin
      ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      din_valid_q <= 1'b0;
      din_q       <= '0;
      issue_tag_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      din_valid_q <= grant_found;
      if (grant_found) begin
        din_q       <= sel_data;
        issue_tag_q <= grant_idx;
      end
    end
  end

  assign pipe_din       = din_q;
  assign pipe_din_valid = din_valid_q;

  assign tag_in.valid = din_valid_q;
  assign tag_in.tag   = MAX_TAG_W'(issue_tag_q);

  pipe_tag_delay #(
    .LATENCY (LATENCY)
  ) u_tag_delay (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // Pipeline outputs during drain are stale leftovers of a pre-reset run.
  assign resp_hit  = !draining && pipe_dout_valid && tag_out.valid;
  assign resp_data = pipe_dout;

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = resp_hit && (tag_out.tag == MAX_TAG_W'(i));
    end
  end

  always_comb begin
    drain_d = drain_q;
    if (draining) drain_d = drain_q - 1'b1;
  end

  // Items are counted from acceptance until their tag leaves the delay line,
  // whether or not the pipeline produced a matching valid.
  always_comb begin
    inflight_d = inflight_q;
    case ({grant_found, tag_out.valid})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  assign orphan_d = orphan_q | (!draining && pipe_dout_valid && !tag_out.valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_q    <= DRAIN_W'(LATENCY);
      inflight_q <= '0;
      orphan_q   <= 1'b0;
    end else begin
      drain_q    <= drain_d;
      inflight_q <= inflight_d;
      orphan_q   <= orphan_d;
    end
  end

  assign busy       = (inflight_q != '0) || draining;
  assign err_orphan = orphan_q;

`ifdef PIPE_ARB_STATS_EN
  logic [STATS_W-1:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (grant_found && (cnt_q[grant_idx] != '1)) begin
      cnt_q[grant_idx] <= cnt_q[grant_idx] + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
    assign grant_cnt[gi*STATS_W +: STATS_W] = cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Bench for pipe_share_arbiter: pipeline model, scoreboard model with an expected
// response queue, per-cycle compare process and directed scenarios.
module tb_pipe_share_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int L  = 5;
  localparam int EW = 24 + 4 + DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            arb_en;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   pipe_din;
  logic            pipe_din_valid;
  logic [DW-1:0]   pipe_dout;
  logic            pipe_dout_valid;
  logic [DW-1:0]   resp_data;
  logic [N-1:0]    resp_valid;
  logic            busy;
  logic            err_orphan;
`ifdef PIPE_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  logic            inj_valid;
  logic [DW-1:0]   inj_data;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_share_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .LATENCY(L)) dut (
    .clk             (clk),
    .rst             (rst),
    .arb_en          (arb_en),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .pipe_din        (pipe_din),
    .pipe_din_valid  (pipe_din_valid),
    .pipe_dout       (pipe_dout),
    .pipe_dout_valid (pipe_dout_valid),
    .resp_data       (resp_data),
    .resp_valid      (resp_valid),
    .busy            (busy),
`ifdef PIPE_ARB_STATS_EN
    .grant_cnt       (grant_cnt),
`endif
    .err_orphan      (err_orphan)
  );

  // Unresettable fixed-latency pipeline, with an injection port for stray valids.
  logic          pv_q [L];
  logic [DW-1:0] pd_q [L];

  always @(posedge clk) begin
    pv_q[0] <= pipe_din_valid;
    pd_q[0] <= pipe_din;
    for (int i = 1; i < L; i++) begin
      pv_q[i] <= pv_q[i-1];
      pd_q[i] <= pd_q[i-1];
    end
  end

  assign pipe_dout_valid = pv_q[L-1] | inj_valid;
  assign pipe_dout       = inj_valid ? inj_data : pd_q[L-1];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Behavioural model: expected responses queue {due_cycle, tag, data}.
  logic [EW-1:0] exp_q[$];
  int            cyc      = 0;
  int            m_drain  = 0;
  int            m_ptr    = 0;
  logic          m_orphan = 1'b0;
  logic          m_issue  = 1'b0;
  logic [DW-1:0] m_din    = '0;
  int            m_cnt [N];
  int            mg;
  logic          m_due;

  function automatic int model_grant();
    if (!arb_en || m_drain > 0) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_drain  = L;
      m_ptr    = 0;
      m_orphan = 1'b0;
      m_issue  = 1'b0;
      m_din    = '0;
      exp_q.delete();
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      m_due = (exp_q.size() > 0) && (exp_q[0][EW-1:EW-24] == 24'(cyc));
      if (m_drain == 0 && pipe_dout_valid && !m_due) m_orphan = 1'b1;
      if (m_due) void'(exp_q.pop_front());
      mg = model_grant();
      if (mg >= 0) begin
        exp_q.push_back({24'(cyc + L + 1), 4'(mg), req_data[mg*DW +: DW]});
        m_ptr   = (mg + 1) % N;
        m_issue = 1'b1;
        m_din   = req_data[mg*DW +: DW];
        if (m_cnt[mg] < 65535) m_cnt[mg]++;
      end else begin
        m_issue = 1'b0;
      end
      if (m_drain > 0) m_drain--;
    end
    cyc++;
  end

  int            cg;
  logic          c_due;
  logic [N-1:0]  c_ready;
  logic [N-1:0]  c_resp;

  always @(negedge clk) begin
    if (!rst) begin
      cg      = model_grant();
      c_ready = (cg >= 0) ? N'(1 << cg) : '0;
      c_due   = (exp_q.size() > 0) && (exp_q[0][EW-1:EW-24] == 24'(cyc));
      c_resp  = c_due ? N'(1 << exp_q[0][DW+3:DW]) : '0;
      chk("req_ready", req_ready, c_ready);
      chk("busy", busy, (m_drain > 0) || (exp_q.size() != 0));
      chk("resp_valid", resp_valid, c_resp);
      if (c_due) chk("resp_data", resp_data, exp_q[0][DW-1:0]);
      chk("err_orphan", err_orphan, m_orphan);
      chk("pipe_din_valid", pipe_din_valid, m_issue);
      chk("pipe_din", pipe_din, m_din);
`ifdef PIPE_ARB_STATS_EN
      for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[i*16 +: 16], 16'(m_cnt[i]));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    n_chk++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    rst       = 1'b1;
    arb_en    = 1'b1;
    req_valid = '0;
    req_data  = '0;
    inj_valid = 1'b0;
    inj_data  = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Drain window with garbage on the pipeline output.
    req_valid = 4'hF;
    req_data  = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    inj_valid = 1'b1;
    inj_data  = 32'hDEAD_BEEF;
    for (int k = 1; k <= L; k++) begin
      #2;
      chk("t1_ready_drain", req_ready, 4'b0000);
      chk("t1_busy_drain", busy, 1'b1);
      chk("t1_resp_drain", resp_valid, 4'b0000);
      chk("t1_orphan_drain", err_orphan, 1'b0);
      tick();
    end
    inj_valid = 1'b0;
    #2 chk("t1_ready_after", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (8) tick();

    // Single requester, single item: LATENCY+1 response latency.
    req_data[2*DW +: DW] = 32'hA5A5_0002;
    req_valid = 4'b0100;
    #2 chk("t2_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    #2;
    chk("t2_din_valid", pipe_din_valid, 1'b1);
    chk("t2_din", pipe_din, 32'hA5A5_0002);
    repeat (5) tick();
    #2;
    chk("t2_resp_valid", resp_valid, 4'b0100);
    chk("t2_resp_data", resp_data, 32'hA5A5_0002);
    repeat (2) tick();

    // All requesters continuously; pointer starts at 3 after the previous grant.
    req_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'h3000_0000 | (k << 8) | i;
      if (k < 4) begin
        #2;
        case (k)
          0: chk("t3_grant0", req_ready, 4'b1000);
          1: chk("t3_grant1", req_ready, 4'b0001);
          2: chk("t3_grant2", req_ready, 4'b0010);
          default: chk("t3_grant3", req_ready, 4'b0100);
        endcase
      end
      tick();
    end

    // Wrap from pointer 3 with only requesters 1 and 3, then disable.
    req_valid = 4'b1010;
    #2 chk("t4_grant3", req_ready, 4'b1000);
    tick();
    #2 chk("t4_grant1", req_ready, 4'b0010);
    tick();
    arb_en = 1'b0;
    #2 chk("t4_no_ready", req_ready, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      if (busy == 1'b0) break;
      tick();
    end
    chk("t4_busy_fall", busy, 1'b0);
    req_valid = '0;
    arb_en    = 1'b1;
    repeat (2) tick();

    // Stray pipeline valid with nothing in flight.
    inj_valid = 1'b1;
    inj_data  = 32'h0BAD_0BAD;
    #2 chk("t5_no_resp", resp_valid, 4'b0000);
    tick();
    inj_valid = 1'b0;
    #2 chk("t5_orphan_set", err_orphan, 1'b1);
    repeat (5) tick();
    #2 chk("t5_orphan_held", err_orphan, 1'b1);

    // Reset with items in flight.
    req_valid = 4'b0001;
    req_data[0 +: DW] = 32'h6000_0000;
    repeat (3) tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2 chk("t6_orphan_clr", err_orphan, 1'b0);
`ifdef PIPE_ARB_STATS_EN
    chk("t6_cnt_clr", grant_cnt, '0);
`endif
    for (int k = 0; k < 10; k++) begin
      tick();
      #2 chk("t6_no_resp", resp_valid, 4'b0000);
    end
    req_data[1*DW +: DW] = 32'h6000_0011;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    repeat (5) tick();
    #2;
    chk("t6_resp_valid", resp_valid, 4'b0010);
    chk("t6_resp_data", resp_data, 32'h6000_0011);

`ifdef PIPE_ARB_STATS_EN
    req_valid = 4'b0001;
    repeat (70000) tick();
    req_valid = '0;
    #2 chk("t6_cnt_sat", grant_cnt[15:0], 16'hFFFF);
`endif

    repeat (10) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
